button_debounce_filter: RTL and testbench
=========================================

// Module: button_debounce_filter
// PURPOSE
//   Parametrised N-channel push-button conditioner for the board front panel (UART/QSPI control buttons).
//   Per channel: synchroniser, counter-based stability filter, debounced level, one-cycle press/release pulses.
//   Sits between raw FPGA button pins and the command/control FSMs; replaces single-flop edge detection.
// PARAMETERS
//   NUM_BTN          5        number of independent button channels
//   SYNC_STAGES      2        synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES  1000000  consecutive stable cycles required to accept a change (10 ms @ 100 MHz), >=1
//   CNT_W            20       filter counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//   ACTIVE_HIGH      1        1: pressed = pin high; 0: pin inverted at input (pressed = pin low)
//   HOLD_CYCLES      50000000 first auto-repeat delay after press (used only with BTN_AUTOREPEAT_EN)
//   REPEAT_CYCLES    10000000 auto-repeat period (used only with BTN_AUTOREPEAT_EN)
// PORTS
//   clk          in   1        system clock
//   rst          in   1        synchronous, active-high reset
//   button_in    in   NUM_BTN  raw asynchronous button pins
//   button_out   out  NUM_BTN  debounced level, 1 = pressed
//   press_out    out  NUM_BTN  1-cycle pulse on accepted press
//   release_out  out  NUM_BTN  1-cycle pulse on accepted release
//   repeat_out   out  NUM_BTN  1-cycle auto-repeat pulse (constant 0 without BTN_AUTOREPEAT_EN)
// BEHAVIOUR
//   - Reset: all sync flops 0 (released), all states RELEASED, counters 0, every output 0.
//   - Channels fully independent; any combination of pulses may assert in the same cycle.
//   - Per-channel FSM; s = synchronised, polarity-corrected input; cnt = filter counter:
//       RELEASED: s=1 -> PRESS_WAIT, cnt<=1; else stay, cnt<=0.
//       PRESS_WAIT: s=0 -> RELEASED, cnt<=0 (bounce restarts filter).
//         s=1 & cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0, press_out pulse; else cnt<=cnt+1.
//       HELD: s=0 -> RELEASE_WAIT, cnt<=1; else stay.
//       RELEASE_WAIT: s=1 -> HELD, cnt<=0, no pulse.
//         s=0 & cnt==DEBOUNCE_CYCLES-1 -> RELEASED, cnt<=0, release_out pulse; else cnt<=cnt+1.
//   - DEBOUNCE_CYCLES=1: the accepting transition occurs on the first edge s differs (no dwell in *_WAIT).
//   - button_out = 1 in HELD and RELEASE_WAIT; all outputs registered.
//   - Latency: clean step on button_in -> button_out/pulse change after SYNC_STAGES+DEBOUNCE_CYCLES edges.
//     press_out/release_out high exactly the first cycle of the new button_out level.
//   - Any stable run shorter than DEBOUNCE_CYCLES cycles produces no output change.
//   - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//   - rst mid-operation: immediate return to reset state; button held through reset re-reports press
//     SYNC_STAGES+DEBOUNCE_CYCLES edges after rst deasserts; no release pulse is generated by reset.
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined:
//     - Per-channel hold counter (width fits HOLD_CYCLES): cleared whenever button_out=0 or on press_out;
//       increments each cycle button_out=1 (incl. RELEASE_WAIT).
//     - repeat_out pulses when hold count reaches HOLD_CYCLES, then every REPEAT_CYCLES after,
//       while button_out stays 1; the count after each repeat reloads, never overflows.
//     - No repeat_out in the cycle release_out asserts or afterwards.
//   BTN_AUTOREPEAT_EN undefined: repeat_out tied 0; no hold counters synthesised; HOLD/REPEAT ignored.
// TESTING  (NUM_BTN=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, ACTIVE_HIGH=1; cycle 0 = edge after stimulus)
//   1 Clean press ch0 held -> press_out[0] high at edge 10 only, button_out[0]=1 from edge 10; ch1-4 stay 0.
//   2 ch1 toggles every 3 cycles for 30 cycles then held 1 -> exactly one press_out[1], 10 edges after last toggle.
//   3 ch2 glitch 7 cycles high -> no press_out, button_out[2] stays 0; 8-cycle pulse -> press accepted.
//   4 Release ch0 and press ch3 same cycle -> release_out[0] and press_out[3] both high at edge 10, same cycle.
//   5 rst 1 cycle while ch4 in PRESS_WAIT (cnt=5) -> all outputs 0; ch4 still held -> press_out[4] 10 edges after rst low.
//   6 BTN_AUTOREPEAT_EN, HOLD_CYCLES=20, REPEAT_CYCLES=5: hold ch0 -> repeat_out[0] at 20,25,30.. cycles after
//     press_out[0]; release -> repeats stop; same stimulus without macro -> repeat_out always 0.

Source files
------------

// File: rtl/button_debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_filter
//  Brief    : N-channel push-button conditioner: synchroniser, stability
//             filter, debounced level and press/release/auto-repeat pulses.
//             Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce_filter #(
    parameter int NUM_BTN         = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_HIGH     = 1,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] button_in,
    output logic [NUM_BTN-1:0] button_out,
    output logic [NUM_BTN-1:0] press_out,
    output logic [NUM_BTN-1:0] release_out,
    output logic [NUM_BTN-1:0] repeat_out
);

    localparam logic [1:0] c_ST_RELEASED     = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_HELD         = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             c_INVERT   = 1'(ACTIVE_HIGH == 0);

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_V   = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_REPEAT_V = c_HOLD_W'(REPEAT_CYCLES);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [1:0]             r_state;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_button;
            logic                   r_press;
            logic                   r_release;

            logic                   w_s;
            logic                   w_last;
            logic [1:0]             w_state_nx;
            logic [CNT_W-1:0]       w_cnt_nx;
            logic                   w_press_nx;
            logic                   w_release_nx;
            logic                   w_button_nx;

            assign w_s    = r_sync[SYNC_STAGES-1];
            // cnt is 0 in the settled states, so w_last there means DEBOUNCE_CYCLES==1
            assign w_last = (r_cnt == c_CNT_LAST);

            always_comb begin
                w_state_nx   = r_state;
                w_cnt_nx     = '0;
                w_press_nx   = 1'b0;
                w_release_nx = 1'b0;
                case (r_state)
                    c_ST_RELEASED: begin
                        if (w_s) begin
                            if (w_last) begin
                                w_state_nx = c_ST_HELD;
                                w_press_nx = 1'b1;
                            end else begin
                                w_state_nx = c_ST_PRESS_WAIT;
                                w_cnt_nx   = CNT_W'(1);
                            end
                        end
                    end
                    c_ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            w_state_nx = c_ST_RELEASED;
                        end else if (w_last) begin
                            w_state_nx = c_ST_HELD;
                            w_press_nx = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                    c_ST_HELD: begin
                        if (!w_s) begin
                            if (w_last) begin
                                w_state_nx   = c_ST_RELEASED;
                                w_release_nx = 1'b1;
                            end else begin
                                w_state_nx = c_ST_RELEASE_WAIT;
                                w_cnt_nx   = CNT_W'(1);
                            end
                        end
                    end
                    c_ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            w_state_nx = c_ST_HELD;
                        end else if (w_last) begin
                            w_state_nx   = c_ST_RELEASED;
                            w_release_nx = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                    default: w_state_nx = c_ST_RELEASED;
                endcase
            end

            assign w_button_nx = (w_state_nx == c_ST_HELD) || (w_state_nx == c_ST_RELEASE_WAIT);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync    <= '0;
                    r_state   <= c_ST_RELEASED;
                    r_cnt     <= '0;
                    r_button  <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_sync    <= {r_sync[SYNC_STAGES-2:0], button_in[gi] ^ c_INVERT};
                    r_state   <= w_state_nx;
                    r_cnt     <= w_cnt_nx;
                    r_button  <= w_button_nx;
                    r_press   <= w_press_nx;
                    r_release <= w_release_nx;
                end
            end

            assign button_out[gi]  = r_button;
            assign press_out[gi]   = r_press;
            assign release_out[gi] = r_release;

`ifdef BTN_AUTOREPEAT_EN
            logic [c_HOLD_W-1:0] r_hold;
            logic                r_rep_phase;
            logic                r_repeat;
            logic [c_HOLD_W-1:0] w_hold_inc;
            logic                w_hold_hit;

            assign w_hold_inc = r_hold + c_HOLD_W'(1);
            // first target is the initial hold delay, afterwards the repeat period
            assign w_hold_hit = (w_hold_inc == (r_rep_phase ? c_REPEAT_V : c_HOLD_V));

            always_ff @(posedge clk) begin
                if (rst || !w_button_nx || w_press_nx) begin
                    r_hold      <= '0;
                    r_rep_phase <= 1'b0;
                    r_repeat    <= 1'b0;
                end else if (w_hold_hit) begin
                    r_hold      <= '0;
                    r_rep_phase <= 1'b1;
                    r_repeat    <= 1'b1;
                end else begin
                    r_hold   <= w_hold_inc;
                    r_repeat <= 1'b0;
                end
            end

            assign repeat_out[gi] = r_repeat;
`else
            assign repeat_out[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_debounce_filter
//  Brief    : Scoreboard bench for button_debounce_filter (directed + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_debounce_filter;

    localparam int NB   = 5;
    localparam int SS   = 2;
    localparam int DB   = 8;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] button_in = '0;
    logic [NB-1:0] button_out;
    logic [NB-1:0] press_out;
    logic [NB-1:0] release_out;
    logic [NB-1:0] repeat_out;

    always #5 clk = ~clk;

    button_debounce_filter #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4),
        .ACTIVE_HIGH    (1),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_in  (button_in),
        .button_out (button_out),
        .press_out  (press_out),
        .release_out(release_out),
        .repeat_out (repeat_out)
    );

    typedef struct {
        logic [NB-1:0] btn;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] rpt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a change is accepted once the synchronised input has
    // disagreed with the accepted level for DB consecutive cycles.
    logic [NB-1:0] hist[$];
    bit            lvl[NB];
    int            run[NB];
    int            age[NB];

    initial begin : model
        exp_t          e;
        logic [NB-1:0] s;
        forever begin
            @(posedge clk);
            e.btn = '0; e.prs = '0; e.rel = '0; e.rpt = '0;
            if (rst) begin
                hist.delete();
                for (int i = 0; i < SS; i++) hist.push_back('0);
                for (int ch = 0; ch < NB; ch++) begin
                    lvl[ch] = 1'b0; run[ch] = 0; age[ch] = 0;
                end
            end else begin
                s = hist.pop_front();
                hist.push_back(button_in);
                for (int ch = 0; ch < NB; ch++) begin
                    if (s[ch] != lvl[ch]) begin
                        run[ch]++;
                        if (run[ch] == DB) begin
                            lvl[ch] = ~lvl[ch];
                            run[ch] = 0;
                            if (lvl[ch]) e.prs[ch] = 1'b1;
                            else         e.rel[ch] = 1'b1;
                        end
                    end else begin
                        run[ch] = 0;
                    end
                    if (e.prs[ch])    age[ch] = 0;
                    else if (lvl[ch]) age[ch]++;
                    e.btn[ch] = lvl[ch];
                    e.rpt[ch] = REPEAT_ON && lvl[ch] && !e.prs[ch] && (age[ch] >= HOLD)
                                && (((age[ch] - HOLD) % REP) == 0);
                end
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got 0 entries expected >=1 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_button_out",  32'(button_out),  32'(e.btn));
                check("sb_press_out",   32'(press_out),   32'(e.prs));
                check("sb_release_out", 32'(release_out), 32'(e.rel));
                check("sb_repeat_out",  32'(repeat_out),  32'(e.rpt));
            end
        end
    end

    // One active edge; inputs are changed and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_pulse(input string name, input int ch, input bit is_rel, input int edges);
        int   early;
        logic p;
        early = 0;
        for (int k = 1; k < edges; k++) begin
            tick();
            p = is_rel ? release_out[ch] : press_out[ch];
            if (p) early++;
        end
        check({name, "_early"}, 32'(early), 32'd0);
        tick();
        p = is_rel ? release_out[ch] : press_out[ch];
        check({name, "_at_edge"}, 32'(p), 32'd1);
    endtask

    task automatic glitch(input int ch, input int len, output int npress, output int maxlvl);
        npress = 0;
        maxlvl = 0;
        button_in[ch] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == len) button_in[ch] = 1'b0;
            if (press_out[ch]) npress++;
            if (button_out[ch]) maxlvl = 1;
        end
    endtask

    initial begin : stimulus
        int cnt;
        int lv;
        int early;
        int remain[NB];

        @(negedge clk);
        repeat (3) tick();
        check("reset_button_out", 32'(button_out), 32'd0);
        check("reset_pulses", 32'({press_out, release_out, repeat_out}), 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // clean press on ch0
        button_in[0] = 1'b1;
        expect_pulse("t1_press0", 0, 1'b0, SS + DB);
        check("t1_button0", 32'(button_out[0]), 32'd1);
        check("t1_others", 32'(button_out[NB-1:1]), 32'd0);
        tick();
        check("t1_press0_one_cycle", 32'(press_out[0]), 32'd0);

        // ch1 bounces with 3-cycle runs, then settles high
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            button_in[1] = ~button_in[1];
            repeat (3) begin
                tick();
                if (press_out[1]) cnt++;
            end
        end
        check("t2_no_press_while_bouncing", 32'(cnt), 32'd0);
        button_in[1] = 1'b1;
        expect_pulse("t2_press1", 1, 1'b0, SS + DB);

        // ch2: run one cycle short of the filter, then exactly the filter length
        glitch(2, DB - 1, cnt, lv);
        check("t3_short_glitch_presses", 32'(cnt), 32'd0);
        check("t3_short_glitch_level", 32'(lv), 32'd0);
        glitch(2, DB, cnt, lv);
        check("t3_exact_run_presses", 32'(cnt), 32'd1);

        // simultaneous release on ch0 and press on ch3
        button_in[0] = 1'b0;
        button_in[3] = 1'b1;
        early = 0;
        for (int k = 1; k < SS + DB; k++) begin
            tick();
            if (release_out[0] || press_out[3]) early++;
        end
        check("t4_early_pulses", 32'(early), 32'd0);
        tick();
        check("t4_same_cycle", 32'({release_out[0], press_out[3]}), 32'b11);

        // reset while ch4 is mid-filter
        button_in[4] = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_reset_button_out", 32'(button_out), 32'd0);
        check("t5_reset_no_release", 32'(release_out), 32'd0);
        expect_pulse("t5_press4", 4, 1'b0, SS + DB);

        // auto-repeat while ch0 is held, and what survives the release filter
        button_in[0] = 1'b1;
        expect_pulse("t6_press0", 0, 1'b0, SS + DB);
        cnt = 0;
        repeat (40) begin
            tick();
            if (repeat_out[0]) cnt++;
        end
        check("t6_repeats_held", 32'(cnt), REPEAT_ON ? 32'd5 : 32'd0);
        button_in[0] = 1'b0;
        cnt = 0;
        repeat (30) begin
            tick();
            if (repeat_out[0]) cnt++;
        end
        check("t6_repeats_after_release", 32'(cnt), REPEAT_ON ? 32'd1 : 32'd0);

        // randomized runs around the filter length, occasional long holds and resets
        for (int ch = 0; ch < NB; ch++) remain[ch] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (remain[ch] == 0) begin
                    button_in[ch] = 1'($urandom_range(0, 1));
                    remain[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                             : int'($urandom_range(1, 10));
                end
                remain[ch]--;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
